// File: rtl/instr_issue_unit.sv
// Instruction issue unit: a circular FIFO of 13-bit instruction words that
// feeds a vector processor. After each issue, ISSUE_GAP NOP cycles follow.
// Optional feature macro: ISSUE_COUNT_EN adds the 16-bit issued_count output.
//
// Handshake: in_valid/in_ready follow strict valid/ready semantics. A word
// transfers on a rising edge where both are high. in_valid must not depend
// on in_ready. in_ready is taken from the registered count only, with no
// same-cycle bypass. The output side has no backpressure: instr_valid marks
// the single cycle in which instruction carries an issued word.
module instr_issue_unit #(
  parameter int          DEPTH     = 8,
  parameter int          ISSUE_GAP = 1,
  parameter logic [12:0] NOP_INSTR = 13'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [12:0]              in_instr,
  output logic                     in_ready,
  input  logic                     hold,
  input  logic                     flush,
  output logic [12:0]              instruction,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
`ifdef ISSUE_COUNT_EN
  ,
  output logic [15:0]              issued_count
`endif
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [3:0]      GAP_LEN = 4'(ISSUE_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [12:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [12:0]   mem_q [DEPTH];

  logic          push_en;
  logic          decide;
  logic          issue;

`ifdef ISSUE_COUNT_EN
  logic [15:0]   issued_q, issued_d;
  assign issued_count = issued_q;
`endif

  assign in_ready    = (count_q < FULL);
  assign count       = count_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

  // A push that coincides with flush is dropped.
  assign push_en = in_valid && in_ready && !flush;

  // Issue decisions happen only on the edges that leave IDLE, leave ISSUE
  // when there is no gap, or end the final GAP cycle.
  always_comb begin
    decide = 1'b0;
    unique case (state_q)
      IDLE:    decide = 1'b1;
      ISSUE:   decide = (ISSUE_GAP == 0);
      GAP:     decide = (gap_q <= 4'd1);
      default: decide = 1'b1;
    endcase
  end

  assign issue = decide && (count_q != '0) && !hold;

  // Next-state, pointer, count and output-register logic.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    instr_d  = NOP_INSTR;
    valid_d  = 1'b0;
`ifdef ISSUE_COUNT_EN
    issued_d = issued_q;
`endif
    if (flush) begin
      state_d  = IDLE;
      gap_d    = 4'd0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        instr_d  = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ISSUE;
        gap_d    = 4'd0;
`ifdef ISSUE_COUNT_EN
        issued_d = issued_q + 16'd1;
`endif
      end else if (decide) begin
        state_d = IDLE;
        gap_d   = 4'd0;
      end else if (state_q == ISSUE) begin
        state_d = GAP;
        gap_d   = GAP_LEN;
      end else begin
        gap_d = gap_q - 4'd1;
      end
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case ({push_en, issue})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers; reset overrides flush, push and issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gap_q    <= 4'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
`ifdef ISSUE_COUNT_EN
      issued_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
`ifdef ISSUE_COUNT_EN
      issued_q <= issued_d;
`endif
    end
  end

  // FIFO storage: written on accepted pushes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: doc/instr_issue_unit.md
INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entries, power of two, range 2..64.
REQ-002 Parameter ISSUE_GAP, default 1, meaning NOP cycles inserted after each issued instruction, range 0..15.
REQ-003 Parameter NOP_INSTR, default 13'h0000, meaning 13-bit value driven on instruction when nothing is issued.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer offers in_instr this cycle.
REQ-007 in_instr  input  13  instruction word: [12:11] opcode, [10:9] reg_sel, [8:0] mem_addr.
REQ-008 in_ready  output  1  FIFO can accept in_instr this cycle.
REQ-009 hold  input  1  suppresses new issue decisions while high.
REQ-010 flush  input  1  discards all buffered instructions.
REQ-011 instruction  output  13  registered instruction word to the vector processor.
REQ-012 instr_valid  output  1  registered; high on the cycle instruction carries a real issued word.
REQ-013 count  output  $clog2(DEPTH)+1  number of buffered entries, 0..DEPTH.

Function
REQ-014 FIFO shall be circular with wrapping read/write pointers; entries issue in arrival order.
REQ-015 in_ready shall equal (count < DEPTH) from registered count, with no bypass; push occurs when in_valid && in_ready.
REQ-016 A word pushed at edge t shall be issuable no earlier than edge t+1; minimum push-to-instr_valid latency is 2 cycles.
REQ-017 States: IDLE, ISSUE, GAP.
REQ-018 Issue decision: at an edge leaving IDLE, ISSUE (ISSUE_GAP==0), or the final GAP cycle, if count>0 and hold==0, load instruction<=head, instr_valid<=1, pop, enter ISSUE; else instruction<=NOP_INSTR, instr_valid<=0, enter IDLE.
REQ-019 ISSUE lasts exactly one cycle; if ISSUE_GAP>0 next state is GAP with instruction=NOP_INSTR, instr_valid=0.
REQ-020 GAP shall last exactly ISSUE_GAP cycles via a 4-bit down-counter; hold does not shorten or abort GAP.
REQ-021 Back-to-back issue spacing shall be exactly ISSUE_GAP+1 cycles while FIFO is non-empty and hold is low.
REQ-022 Simultaneous push and pop shall leave count unchanged; at count==DEPTH, pop frees a slot visible as in_ready=1 the next cycle.
REQ-023 flush shall, at the edge, clear count and pointers, drive instruction=NOP_INSTR, instr_valid=0, state IDLE; a same-cycle push is dropped.
REQ-024 flush during ISSUE shall not retract the word already presented; it ends the following cycle.

Reset
REQ-025 rst shall set count=0, pointers=0, state=IDLE, gap counter=0, instruction=NOP_INSTR, instr_valid=0; rst has priority over flush, push, and issue.
REQ-026 rst asserted mid-GAP or mid-ISSUE shall abandon the operation; buffered words are lost.
REQ-027 FIFO storage array is not reset.

Configuration
REQ-028 With ISSUE_COUNT_EN defined, output issued_count[15:0] shall increment once per issue, wrap 16'hFFFF->16'h0000, clear on rst only (not flush).
REQ-029 Without ISSUE_COUNT_EN, port issued_count and its register shall not exist; all other behaviour is identical.

Verification
REQ-030 ISSUE_GAP=1; push 13'h0A05,13'h1203,13'h1C10 on consecutive cycles -> instr_valid high on cycles 2,4,6 after first push carrying those words in order; NOP_INSTR between.
REQ-031 DEPTH=8, hold=1; push 9 words -> in_ready=0 after 8th, count=8, 9th dropped; release hold -> 8 words issue in order, count reaches 0.
REQ-032 ISSUE_GAP=0, FIFO holding 4 words -> instr_valid high 4 consecutive cycles; hold raised on 3rd -> 3rd word still issued, 4th waits until hold low.
REQ-033 3 words buffered, flush with in_valid=1 same cycle -> next cycle count=0, instr_valid=0, instruction=NOP_INSTR, no later issue.
REQ-034 rst asserted during GAP with 5 words buffered -> next cycle count=0, state IDLE, outputs NOP_INSTR/0; issued_count (ISSUE_COUNT_EN) =0.
REQ-035 ISSUE_COUNT_EN, counter preloaded near 16'hFFFF via 65535 issues then 1 more -> issued_count=16'h0000.
